hazard_scoreboard_unit: RTL and testbench

- Next-generation hazard/forwarding controller for the 5-stage MIPS pipeline.
- Adds four things:
  - a sequential busy tracker for a multi-cycle MUL/DIV unit (HI/LO),
  - operand-use qualification so false load-use stalls are removed,
  - a parameter for the branch-resolve stage,
  - redirect-over-stall priority.
- Sits beside the datapath. Drives the forwarding muxes in E and the stall/flush controls of the F/D/E/M pipeline registers.

---
 rtl/hazard_scoreboard_unit_pkg.sv | 13 +
 rtl/hazard_scoreboard_unit_if.sv | 32 +++
 rtl/hazard_scoreboard_unit_tracker.sv | 37 +++
 rtl/hazard_scoreboard_unit.sv | 76 +++++++
 tb/tb_hazard_scoreboard_unit.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/hazard_scoreboard_unit_pkg.sv
// Shared types and constants for the hazard/forwarding scoreboard.
// Forward-select encodings match the E-stage operand mux.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  localparam int MULDIV_CNT_W = 8;

endpackage

// File: rtl/hazard_scoreboard_unit_if.sv
// Pipeline-side bundle for the hazard scoreboard: register ids and control
// from D/E/M/W in, forward selects and stall/flush controls out.
interface hazard_scoreboard_unit_if #(
  parameter int REG_AW = 5
);

  logic [REG_AW-1:0] rsD, rtD, rsE, rtE, WriteRegM, WriteRegW;
  logic              UsesRsD, UsesRtD, MemToRegE;
  logic              RegWriteM, RegWriteW;
  logic              Jump, PCSrc;
  logic              MulDivStartD, HiLoReadD, MulDivStartE;
  logic [1:0]        ForwardAE, ForwardBE;
  logic              StallF, StallD, FlushD, FlushE, FlushM;
  logic              MulDivBusy, MulDivDone;

  modport master (
    output rsD, rtD, UsesRsD, UsesRtD, rsE, rtE, MemToRegE,
           RegWriteM, WriteRegM, RegWriteW, WriteRegW,
           Jump, PCSrc, MulDivStartD, HiLoReadD, MulDivStartE,
    input  ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE, FlushM,
           MulDivBusy, MulDivDone
  );

  modport slave (
    input  rsD, rtD, UsesRsD, UsesRtD, rsE, rtE, MemToRegE,
           RegWriteM, WriteRegM, RegWriteW, WriteRegW,
           Jump, PCSrc, MulDivStartD, HiLoReadD, MulDivStartE,
    output ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE, FlushM,
           MulDivBusy, MulDivDone
  );

endinterface

// File: rtl/hazard_scoreboard_unit_tracker.sv
// Occupancy counter for the multi-cycle MUL/DIV unit; the only state in the
// hazard scoreboard.
module muldiv_busy_tracker
  import hazard_pkg::*;
#(
  parameter int MULDIV_CYCLES = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    accE,
  output logic [MULDIV_CNT_W-1:0] cnt,
  output logic                    busy,
  output logic                    done,
  output logic                    pending_gt1
);

  logic [MULDIV_CNT_W-1:0] cnt_r;

  // Load on accept (a stray accept mid-operation reloads), otherwise count down to idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= 8'd0;
    end else if (accE) begin
      cnt_r <= MULDIV_CNT_W'(MULDIV_CYCLES);
    end else if (cnt_r != 8'd0) begin
      cnt_r <= cnt_r - 8'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt         = cnt_r;
  assign busy        = (cnt_r != 8'd0);
  assign done        = (cnt_r == 8'd1);
  assign pending_gt1 = (cnt_r > 8'd1);

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Hazard/forwarding controller for the 5-stage MIPS pipeline: E-stage
// forwarding, load-use and MUL/DIV stalls, and redirect-over-stall flushes.
module hazard_scoreboard_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW        = 5,
  parameter int MULDIV_CYCLES = 32,
  parameter int BRANCH_IN_M   = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  hazard_scoreboard_unit_if.slave hz
);

  localparam logic BR_M = (BRANCH_IN_M != 0);

  logic [MULDIV_CNT_W-1:0] cnt_s;
  logic acc_e_s, busy_s, done_s, pending_gt1_s;
  logic lw_stall_s, md_stall_s, stall_s;
  logic unused_cnt_s;

  // M-stage result wins over W; register 0 is never forwarded.
  function automatic fwd_sel_e fwd_pick(
    input logic [REG_AW-1:0] src,
    input logic [REG_AW-1:0] wr_m,
    input logic              we_m,
    input logic [REG_AW-1:0] wr_w,
    input logic              we_w
  );
    if ((src != {REG_AW{1'b0}}) && (src == wr_m) && we_m) begin
      return FWD_MEM;
    end else if ((src != {REG_AW{1'b0}}) && (src == wr_w) && we_w) begin
      return FWD_WB;
    end else begin
      return FWD_RF;
    end
  endfunction

  assign acc_e_s = hz.MulDivStartE && !(BR_M && hz.PCSrc);

  muldiv_busy_tracker #(
    .MULDIV_CYCLES(MULDIV_CYCLES)
  ) u_tracker (
    .clk        (clk),
    .reset      (reset),
    .accE       (acc_e_s),
    .cnt        (cnt_s),
    .busy       (busy_s),
    .done       (done_s),
    .pending_gt1(pending_gt1_s)
  );

  assign unused_cnt_s = ^cnt_s;

  assign hz.ForwardAE = fwd_pick(hz.rsE, hz.WriteRegM, hz.RegWriteM, hz.WriteRegW, hz.RegWriteW);
  assign hz.ForwardBE = fwd_pick(hz.rtE, hz.WriteRegM, hz.RegWriteM, hz.WriteRegW, hz.RegWriteW);

  // Only operands the D instruction really reads can cause a load-use stall.
  assign lw_stall_s = hz.MemToRegE && (hz.rtE != {REG_AW{1'b0}}) &&
                      ((hz.UsesRsD && (hz.rsD == hz.rtE)) ||
                       (hz.UsesRtD && (hz.rtD == hz.rtE)));

  // At cnt==1 the dependent op may advance: it reaches E as the unit goes idle.
  assign md_stall_s = (hz.HiLoReadD || hz.MulDivStartD) && (pending_gt1_s || acc_e_s);
  assign stall_s    = lw_stall_s || md_stall_s;

  // A taken redirect overrides any stall; a stalled jump is kept in D.
  assign hz.StallF     = stall_s && !hz.PCSrc;
  assign hz.StallD     = stall_s && !hz.PCSrc;
  assign hz.FlushD     = hz.PCSrc || (hz.Jump && !stall_s);
  assign hz.FlushE     = stall_s || hz.PCSrc;
  assign hz.FlushM     = BR_M && hz.PCSrc;
  assign hz.MulDivBusy = busy_s;
  assign hz.MulDivDone = done_s;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed bench: combinational vector table plus multi-cycle MUL/DIV,
// redirect and reset sequences across three parameterisations.
module tb_hazard_scoreboard_unit;
  import hazard_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_scoreboard_unit_if #(.REG_AW(5)) ia ();
  hazard_scoreboard_unit_if #(.REG_AW(5)) ib ();
  hazard_scoreboard_unit_if #(.REG_AW(5)) ic ();

  // a: 4-cycle unit, branch in M; b: 4-cycle unit, branch in E; c: 32-cycle unit, branch in M
  hazard_scoreboard_unit #(.REG_AW(5), .MULDIV_CYCLES(4),  .BRANCH_IN_M(1)) dut_a (.clk(clk), .reset(reset), .hz(ia));
  hazard_scoreboard_unit #(.REG_AW(5), .MULDIV_CYCLES(4),  .BRANCH_IN_M(0)) dut_b (.clk(clk), .reset(reset), .hz(ib));
  hazard_scoreboard_unit #(.REG_AW(5), .MULDIV_CYCLES(32), .BRANCH_IN_M(1)) dut_c (.clk(clk), .reset(reset), .hz(ic));

  assign ib.rsD = ia.rsD;             assign ic.rsD = ia.rsD;
  assign ib.rtD = ia.rtD;             assign ic.rtD = ia.rtD;
  assign ib.UsesRsD = ia.UsesRsD;     assign ic.UsesRsD = ia.UsesRsD;
  assign ib.UsesRtD = ia.UsesRtD;     assign ic.UsesRtD = ia.UsesRtD;
  assign ib.rsE = ia.rsE;             assign ic.rsE = ia.rsE;
  assign ib.rtE = ia.rtE;             assign ic.rtE = ia.rtE;
  assign ib.MemToRegE = ia.MemToRegE; assign ic.MemToRegE = ia.MemToRegE;
  assign ib.RegWriteM = ia.RegWriteM; assign ic.RegWriteM = ia.RegWriteM;
  assign ib.WriteRegM = ia.WriteRegM; assign ic.WriteRegM = ia.WriteRegM;
  assign ib.RegWriteW = ia.RegWriteW; assign ic.RegWriteW = ia.RegWriteW;
  assign ib.WriteRegW = ia.WriteRegW; assign ic.WriteRegW = ia.WriteRegW;
  assign ib.Jump = ia.Jump;           assign ic.Jump = ia.Jump;
  assign ib.PCSrc = ia.PCSrc;         assign ic.PCSrc = ia.PCSrc;
  assign ib.MulDivStartD = ia.MulDivStartD; assign ic.MulDivStartD = ia.MulDivStartD;
  assign ib.HiLoReadD = ia.HiLoReadD;       assign ic.HiLoReadD = ia.HiLoReadD;
  assign ib.MulDivStartE = ia.MulDivStartE; assign ic.MulDivStartE = ia.MulDivStartE;

  // {FwdA, FwdB, StallF, StallD, FlushD, FlushE, FlushM, Busy, Done}
  wire [10:0] out_a = {ia.ForwardAE, ia.ForwardBE, ia.StallF, ia.StallD, ia.FlushD,
                       ia.FlushE, ia.FlushM, ia.MulDivBusy, ia.MulDivDone};
  wire [10:0] out_b = {ib.ForwardAE, ib.ForwardBE, ib.StallF, ib.StallD, ib.FlushD,
                       ib.FlushE, ib.FlushM, ib.MulDivBusy, ib.MulDivDone};
  wire [10:0] out_c = {ic.ForwardAE, ic.ForwardBE, ic.StallF, ic.StallD, ic.FlushD,
                       ic.FlushE, ic.FlushM, ic.MulDivBusy, ic.MulDivDone};

  typedef struct {
    logic [4:0] rsD, rtD;
    logic       usr, usrt;
    logic [4:0] rsE, rtE;
    logic       m2r, rwm;
    logic [4:0] wm;
    logic       rww;
    logic [4:0] ww;
    logic       jump, pcsrc, hilo, mdsd;
    logic [10:0] exp;
  } vec_t;

  localparam logic [10:0] NO_FLUSHM = 11'b111_1111_1011;

  vec_t vecs[14];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int idx, input logic [10:0] got, input logic [10:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %b want %b", nm, idx, got, exp);
    end
  endtask

  task automatic clear_inputs();
    ia.rsD = 5'd0; ia.rtD = 5'd0; ia.UsesRsD = 1'b0; ia.UsesRtD = 1'b0;
    ia.rsE = 5'd0; ia.rtE = 5'd0; ia.MemToRegE = 1'b0;
    ia.RegWriteM = 1'b0; ia.WriteRegM = 5'd0; ia.RegWriteW = 1'b0; ia.WriteRegW = 5'd0;
    ia.Jump = 1'b0; ia.PCSrc = 1'b0;
    ia.MulDivStartD = 1'b0; ia.HiLoReadD = 1'b0; ia.MulDivStartE = 1'b0;
  endtask

  task automatic set_lwstall();
    ia.MemToRegE = 1'b1; ia.rtE = 5'd8; ia.rsD = 5'd8; ia.UsesRsD = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  logic [10:0] s1_exp[6];

  initial begin
    //            rsD   rtD   usr   usrt  rsE   rtE   m2r   rwm   wm    rww   ww    jump  pcsrc hilo  mdsd  exp
    vecs[0]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 11'b10_10_0000000};
    vecs[1]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 5'd5, 1'b0, 1'b0, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 11'b01_01_0000000};
    vecs[2]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 11'b00_00_0000000};
    vecs[3]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 5'd7, 1'b0, 1'b1, 5'd3, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 11'b10_01_0000000};
    vecs[4]  = '{5'd8, 5'd0, 1'b1, 1'b0, 5'd0, 5'd8, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 11'b00_00_1101000};
    vecs[5]  = '{5'd8, 5'd8, 1'b0, 1'b0, 5'd0, 5'd8, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 11'b00_00_0000000};
    vecs[6]  = '{5'd1, 5'd8, 1'b1, 1'b1, 5'd0, 5'd8, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 11'b00_00_1101000};
    vecs[7]  = '{5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 11'b00_00_0000000};
    vecs[8]  = '{5'd8, 5'd0, 1'b1, 1'b0, 5'd0, 5'd8, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 11'b00_00_0011100};
    vecs[9]  = '{5'd8, 5'd0, 1'b1, 1'b0, 5'd0, 5'd8, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 11'b00_00_1101000};
    vecs[10] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 11'b00_00_0010000};
    vecs[11] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 11'b00_00_0011100};
    vecs[12] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 11'b00_00_0000000};
    vecs[13] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd4, 5'd6, 1'b0, 1'b1, 5'd6, 1'b0, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0, 11'b00_10_0000000};

    // Reset state
    do_reset();
    @(negedge clk);
    chk("reset_a", 0, out_a, 11'b0);
    chk("reset_b", 0, out_b, 11'b0);
    chk("reset_c", 0, out_c, 11'b0);
    tick();

    // Combinational vectors; unit idle throughout
    for (int i = 0; i < 14; i++) begin
      ia.rsD = vecs[i].rsD; ia.rtD = vecs[i].rtD; ia.UsesRsD = vecs[i].usr; ia.UsesRtD = vecs[i].usrt;
      ia.rsE = vecs[i].rsE; ia.rtE = vecs[i].rtE; ia.MemToRegE = vecs[i].m2r;
      ia.RegWriteM = vecs[i].rwm; ia.WriteRegM = vecs[i].wm;
      ia.RegWriteW = vecs[i].rww; ia.WriteRegW = vecs[i].ww;
      ia.Jump = vecs[i].jump; ia.PCSrc = vecs[i].pcsrc;
      ia.HiLoReadD = vecs[i].hilo; ia.MulDivStartD = vecs[i].mdsd; ia.MulDivStartE = 1'b0;
      @(negedge clk);
      chk("vec_a", i, out_a, vecs[i].exp);
      chk("vec_b", i, out_b, vecs[i].exp & NO_FLUSHM);
      tick();
    end

    // MUL/DIV launch with HiLo read held, overlapping load-use in cycle 2
    s1_exp[0] = 11'b00_00_1101000;
    s1_exp[1] = 11'b00_00_1101010;
    s1_exp[2] = 11'b00_00_1101010;
    s1_exp[3] = 11'b00_00_1101010;
    s1_exp[4] = 11'b00_00_0000011;
    s1_exp[5] = 11'b00_00_0000000;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      clear_inputs();
      ia.HiLoReadD = 1'b1;
      ia.MulDivStartE = (c == 0) ? 1'b1 : 1'b0;
      if (c == 2) set_lwstall();
      @(negedge clk);
      chk("muldiv_a", c, out_a, s1_exp[c]);
      chk("muldiv_b", c, out_b, s1_exp[c]);
      tick();
    end

    // Wrong-path MUL/DIV under a taken redirect: blocked only when the branch resolves in M
    do_reset();
    ia.MulDivStartE = 1'b1; ia.PCSrc = 1'b1;
    @(negedge clk);
    chk("redir_a", 0, out_a, 11'b00_00_0011100);
    chk("redir_b", 0, out_b, 11'b00_00_0011000);
    tick();
    clear_inputs();
    @(negedge clk);
    chk("redir_a", 1, out_a, 11'b00_00_0000000);
    chk("redir_b", 1, out_b, 11'b00_00_0000010);
    tick();

    // Reset while the 32-cycle unit is at cnt==20
    do_reset();
    ia.MulDivStartE = 1'b1;
    tick();
    clear_inputs();
    for (int k = 0; k < 12; k++) tick();
    ia.HiLoReadD = 1'b1;
    @(negedge clk);
    chk("midrst_c", 0, out_c, 11'b00_00_1101010);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_c", 1, out_c, 11'b00_00_0000000);
    tick();
    @(negedge clk);
    chk("midrst_c", 2, out_c, 11'b00_00_0000000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
